// File: rtl/alu_op_decode.sv
// alu_op_decode: decode stage turning 16-bit instruction words into ALU
// control packets, with one registered output packet and HALT/exception
// sequencing. Optional statistics counters are built only when the macro
// DECODE_STATS_EN is defined; otherwise stat_* are tied to zero.
module alu_op_decode #(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        alu_op,
    output logic              alu_sign,
    output logic              imm_sel,
    output logic [15:0]       imm,
    output logic [2:0]        rs,
    output logic [2:0]        rt,
    output logic [2:0]        rd,
    output logic              ctrl_err,
    output logic              halted,
    output logic [STAT_W-1:0] stat_retired,
    output logic [STAT_W-1:0] stat_stall
);
    localparam logic [4:0] OP_SIIC = 5'd26, OP_RTI = 5'd27, OP_NOP = 5'd28, OP_HALT = 5'd29;

    typedef struct packed {
        logic [4:0]  op;
        logic        sign;
        logic        imm_sel;
        logic [15:0] imm;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  rd;
        logic        err;
    } pkt_t;

    typedef enum logic [1:0] {S_RUN, S_EXC, S_HALTED} state_t;

    state_t      state, state_nx;
    pkt_t        pkt, dec;
    logic [4:0]  opc;
    logic [15:0] s5, z5, s8, z8, s11;
    logic        pending_siic, ctrl, accept, retire;

    assign opc = instr[15:11];
    assign s5  = {{11{instr[4]}}, instr[4:0]};
    assign z5  = {11'd0, instr[4:0]};
    assign s8  = {{8{instr[7]}}, instr[7:0]};
    assign z8  = {8'd0, instr[7:0]};
    assign s11 = {{5{instr[10]}}, instr[10:0]};

    // An SIIC sitting in the output register counts as already entered
    assign pending_siic = out_valid && (pkt.op == OP_SIIC);
    assign ctrl   = out_valid && (pkt.op inside {OP_HALT, OP_SIIC, OP_RTI});
    assign in_ready = !flush && (state != S_HALTED) && (!out_valid || (out_ready && !ctrl));
    assign accept = in_valid && in_ready;
    assign retire = out_valid && out_ready && !flush;

    // Combinational decode of the incoming word, including illegal-sequence squash
    always_comb begin
        dec         = '0;
        dec.op      = OP_NOP;
        dec.sign    = 1'b1;
        dec.rs      = instr[10:8];
        dec.rt      = instr[7:5];
        dec.rd      = instr[4:2];
        case (opc)
            5'b00000: dec.op = OP_HALT;
            5'b00001: dec.op = OP_NOP;
            5'b00010: dec.op = OP_SIIC;
            5'b00011: dec.op = OP_RTI;
            5'b00100: begin dec.op = 5'd21; dec.imm_sel = 1'b1; dec.imm = s11; end
            5'b00101: begin dec.op = 5'd23; dec.imm_sel = 1'b1; dec.imm = s8;  end
            5'b00110: begin dec.op = 5'd22; dec.imm_sel = 1'b1; dec.imm = s11; end
            5'b00111: begin dec.op = 5'd24; dec.imm_sel = 1'b1; dec.imm = s8;  end
            5'b01000: begin dec.op = 5'd0;  dec.imm_sel = 1'b1; dec.imm = s5;  end
            5'b01001: begin dec.op = 5'd1;  dec.imm_sel = 1'b1; dec.imm = s5;  end
            5'b01010: begin dec.op = 5'd2;  dec.imm_sel = 1'b1; dec.imm = z5; dec.sign = 1'b0; end
            5'b01011: begin dec.op = 5'd3;  dec.imm_sel = 1'b1; dec.imm = z5; dec.sign = 1'b0; end
            5'b01100: begin dec.op = 5'd16; dec.imm_sel = 1'b1; dec.imm = s8;  end
            5'b01101: begin dec.op = 5'd17; dec.imm_sel = 1'b1; dec.imm = s8;  end
            5'b01110: begin dec.op = 5'd18; dec.imm_sel = 1'b1; dec.imm = s8;  end
            5'b01111: dec.op = 5'd25;
            5'b10000: begin dec.op = 5'd8;  dec.imm_sel = 1'b1; dec.imm = s5;  end
            5'b10001: begin dec.op = 5'd9;  dec.imm_sel = 1'b1; dec.imm = s5;  end
            5'b10010: begin dec.op = 5'd20; dec.imm_sel = 1'b1; dec.imm = z8;  end
            5'b10011: begin dec.op = 5'd10; dec.imm_sel = 1'b1; dec.imm = s5;  end
            5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
                dec.op      = 5'd4 + {3'd0, opc[1:0]};
                dec.imm_sel = 1'b1;
                dec.imm     = z5;
                dec.sign    = 1'b0;
            end
            5'b11000: begin dec.op = 5'd19; dec.imm_sel = 1'b1; dec.imm = s8;  end
            5'b11001: dec.op = 5'd11;
            5'b11010: begin dec.op = 5'd4 + {3'd0, instr[1:0]}; dec.sign = 1'b0; end
            5'b11011: begin
                dec.op   = {3'd0, instr[1:0]};
                dec.sign = !instr[1];
            end
            5'b11100: dec.op = 5'd12;
            5'b11101: dec.op = 5'd13;
            5'b11110: dec.op = 5'd14;
            default:  begin dec.op = 5'd15; dec.sign = 1'b0; end
        endcase
        if (dec.op == OP_SIIC && (state == S_EXC || pending_siic)) begin
            dec.op  = OP_NOP;
            dec.err = 1'b1;
        end
        if (dec.op == OP_RTI && state == S_RUN && !pending_siic) begin
            dec.op  = OP_NOP;
            dec.err = 1'b1;
        end
    end

    // Single output register: flush beats accept, accept beats plain retire
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            pkt       <= '{op: OP_NOP, default: '0};
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            pkt       <= dec;
        end else if (retire) begin
            out_valid <= 1'b0;
        end
    end

    // Control-state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_RUN;
        else     state <= state_nx;
    end

    // Control-state transitions, only on retire
    always_comb begin
        state_nx = state;
        if (retire) begin
            case (state)
                S_RUN: begin
                    if (pkt.op == OP_HALT)      state_nx = S_HALTED;
                    else if (pkt.op == OP_SIIC) state_nx = S_EXC;
                end
                S_EXC: begin
                    if (pkt.op == OP_HALT)      state_nx = S_HALTED;
                    else if (pkt.op == OP_RTI)  state_nx = S_RUN;
                end
                default: state_nx = state;
            endcase
        end
    end

`ifdef DECODE_STATS_EN
    logic [STAT_W-1:0] retired_q, stall_q;

    // Free-running wrap-around retire and stall counters
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (retire)               retired_q <= retired_q + 1'b1;
            if (in_valid && !in_ready) stall_q  <= stall_q + 1'b1;
        end
    end

    assign stat_retired = retired_q;
    assign stat_stall   = stall_q;
`else
    assign stat_retired = '0;
    assign stat_stall   = '0;
`endif

    assign alu_op   = pkt.op;
    assign alu_sign = pkt.sign;
    assign imm_sel  = pkt.imm_sel;
    assign imm      = pkt.imm;
    assign rs       = pkt.rs;
    assign rt       = pkt.rt;
    assign rd       = pkt.rd;
    assign ctrl_err = pkt.err;
    assign halted   = (state == S_HALTED);
endmodule

// File: tb/tb_alu_op_decode.sv
// Bench for alu_op_decode: reference model checked every cycle plus
// hand-computed literal expectations along a directed sequence.
module tb_alu_op_decode;
    localparam int STAT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic [15:0] instr = 16'h0;
    logic in_ready, out_valid, alu_sign, imm_sel, ctrl_err, halted;
    logic [4:0] alu_op;
    logic [15:0] imm;
    logic [2:0] rs, rt, rd;
    logic [STAT_W-1:0] stat_retired, stat_stall;

    always #5 clk = ~clk;

    alu_op_decode #(.STAT_W(STAT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
        .alu_sign(alu_sign), .imm_sel(imm_sel), .imm(imm), .rs(rs), .rt(rt), .rd(rd),
        .ctrl_err(ctrl_err), .halted(halted), .stat_retired(stat_retired), .stat_stall(stat_stall)
    );

    typedef struct packed {
        logic [4:0]  op;
        logic        sign;
        logic        imm_sel;
        logic [15:0] imm;
        logic [2:0]  rs, rt, rd;
        logic        err;
    } pkt_t;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // opcode -> op (-1 register shift, -2 register arith); immediate kind:
    // 0 none, 1 sext5, 2 zext5, 3 sext8, 4 zext8, 5 sext11
    int otab [0:31] = '{29,28,26,27,21,23,22,24, 0,1,2,3,16,17,18,25,
                        8,9,20,10,4,5,6,7, 19,11,-1,-2,12,13,14,15};
    int ktab [0:31] = '{0,0,0,0,5,3,5,3, 1,1,2,2,3,3,3,0,
                        1,1,4,1,2,2,2,2, 3,0,0,0,0,0,0,0};

    function automatic pkt_t mdec(input logic [15:0] i, input int mode, input bit pend);
        pkt_t p;
        int op, k, v;
        op = otab[i[15:11]];
        k  = ktab[i[15:11]];
        if (op == -1) op = 4 + int'(i[1:0]);
        if (op == -2) op = int'(i[1:0]);
        case (k)
            1: v = int'(i[4:0]) - (i[4] ? 32 : 0);
            2: v = int'(i[4:0]);
            3: v = int'(i[7:0]) - (i[7] ? 256 : 0);
            4: v = int'(i[7:0]);
            5: v = int'(i[10:0]) - (i[10] ? 2048 : 0);
            default: v = 0;
        endcase
        p.err = 1'b0;
        if (op == 26 && (mode == 1 || pend)) begin op = 28; p.err = 1'b1; end
        if (op == 27 && mode == 0 && !pend)  begin op = 28; p.err = 1'b1; end
        p.op      = op[4:0];
        p.sign    = !(op inside {2, 3, 4, 5, 6, 7, 15});
        p.imm_sel = (k != 0);
        p.imm     = v[15:0];
        p.rs = i[10:8]; p.rt = i[7:5]; p.rd = i[4:2];
        return p;
    endfunction

    // Model state: mode 0 run, 1 exception, 2 halted
    bit          m_valid = 1'b0;
    int          m_mode = 0;
    pkt_t        m_pkt;
    logic [15:0] m_ret = '0, m_stall = '0;

    function automatic bit m_ready();
        bit c;
        c = m_valid && (m_pkt.op inside {5'd26, 5'd27, 5'd29});
        return !flush && m_mode != 2 && (!m_valid || (out_ready && !c));
    endfunction

    // Reference model advance
    always @(posedge clk) begin : model
        bit rdy, ret;
        if (rst) begin
            m_valid <= 1'b0; m_mode <= 0; m_ret <= '0; m_stall <= '0;
        end else begin
            rdy = m_ready();
            ret = m_valid && out_ready && !flush;
            if (ret) begin
                if (m_pkt.op == 29 && m_mode != 2)       m_mode <= 2;
                else if (m_mode == 0 && m_pkt.op == 26)  m_mode <= 1;
                else if (m_mode == 1 && m_pkt.op == 27)  m_mode <= 0;
                m_ret <= m_ret + 16'd1;
            end
            if (in_valid && !rdy) m_stall <= m_stall + 16'd1;
            if (flush) m_valid <= 1'b0;
            else if (in_valid && rdy) begin
                m_valid <= 1'b1;
                m_pkt   <= mdec(instr, m_mode, m_valid && m_pkt.op == 26);
            end else if (ret) m_valid <= 1'b0;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", in_ready, m_ready());
            chk("out_valid", out_valid, m_valid);
            chk("halted", halted, m_mode == 2);
            if (m_valid) chk("packet", {alu_op, alu_sign, imm_sel, imm, rs, rt, rd, ctrl_err}, m_pkt);
`ifdef DECODE_STATS_EN
            chk("stat_retired", stat_retired, m_ret);
            chk("stat_stall", stat_stall, m_stall);
`else
            chk("stat_tied", {stat_retired, stat_stall}, 32'd0);
`endif
        end
    end

    task automatic issue(input logic [15:0] w);
        in_valid = 1'b1; instr = w;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        @(posedge clk); #1;
    endtask

    logic [15:0] sweep [0:11] = '{16'hD003, 16'hDB02, 16'hFFFF, 16'hC0FF, 16'h8010, 16'h7800,
                                  16'hC800, 16'h2C85, 16'h6080, 16'h9080, 16'hA7E3, 16'h3DFF};

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_op", alu_op, 28);
        chk("rst_fields", {alu_sign, imm_sel, imm, rs, rt, rd, ctrl_err, halted}, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_stats", {stat_retired, stat_stall}, 0);
        #1;

        issue(16'hDA01);
        chk("rsub_valid", out_valid, 1);
        chk("rsub_op", alu_op, 1);
        chk("rsub_sel_sign", {imm_sel, alu_sign}, 2'b01);
        chk("rsub_regs", {rs, rt, rd}, {3'd2, 3'd0, 3'd0});
        drain();
        issue(16'h403F);
        chk("addi_imm", imm, 16'hFFFF);
        chk("addi_sel", imm_sel, 1);
        drain();
        issue(16'h503F);
        chk("ori_imm", imm, 16'h001F);
        chk("ori_sign", alu_sign, 0);
        drain();
        issue(16'h2400);
        chk("j_op", alu_op, 21);
        chk("j_imm", imm, 16'hFC00);
        drain();

        // Back-to-back stream of assorted forms
        for (int n = 0; n < 12; n++) begin
            in_valid = 1'b1; instr = sweep[n];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();

        // Backpressure: held packet must stay put, input must stall
        out_ready = 1'b0; in_valid = 1'b1; instr = 16'h4801;
        @(posedge clk); #1 instr = 16'h0801;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("stall_ready", in_ready, 0);
            chk("stall_hold", {alu_op, imm}, {5'd1, 16'h0001});
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
`ifdef DECODE_STATS_EN
        @(negedge clk);
        chk("stat_stall3", stat_stall, 3);
`endif
        drain();

        // Exception sequencing
        issue(16'h1000); chk("siic1", {alu_op, ctrl_err}, {5'd26, 1'b0}); drain();
        issue(16'h1000); chk("siic2", {alu_op, ctrl_err}, {5'd28, 1'b1}); drain();
        issue(16'h1800); chk("rti1",  {alu_op, ctrl_err}, {5'd27, 1'b0}); drain();
        issue(16'h1800); chk("rti2",  {alu_op, ctrl_err}, {5'd28, 1'b1}); drain();

        // HALT retires, decoder locks until reset
        issue(16'h0000);
        chk("halt_op", alu_op, 29);
        drain();
        in_valid = 1'b1; instr = 16'h0801;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("halted_lock", {halted, in_ready}, 2'b10);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("unhalt", {halted, in_ready}, 2'b01);
        #1;

        // Held HALT flushed; flush also blocks the concurrent input
        out_ready = 1'b0;
        issue(16'h0000);
        chk("halt_held", {out_valid, alu_op}, {1'b1, 5'd29});
        flush = 1'b1; in_valid = 1'b1; instr = 16'hDA01;
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flushed", {out_valid, halted, in_ready}, 3'b001);
        #1 out_ready = 1'b1;
        issue(16'hDA01);
        chk("post_flush", {out_valid, alu_op}, {1'b1, 5'd1});
        drain();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
